led7219_sink: RTL

- Receive side of the MAX7219 daisy-chain serial link that led7219 drives (DIN/CS/CLK).
- Oversamples the three link lines in the system clock domain and shifts in 16-bit words per device.
- On the CS rising edge, decodes the words into a per-device display image plus control registers.
- Used as an on-board loopback and self-check of the LED debug matrix: exp2 pins feed back into it. Also serves as the scoreboard model in simulation.

---
 rtl/led7219_sink.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/led7219_sink.sv
// Receiver for a MAX7219 daisy-chain link: oversamples DIN/CS/CLK, shifts in one 16-bit word
// per device and decodes the words into a display image and control registers on CS rise.
module led7219_sink #(
  parameter int unsigned NDEV        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                leds_din,
  input  logic                leds_cs,
  input  logic                leds_clk,
  output logic [NDEV*64-1:0]  image,
  output logic [NDEV*8-1:0]   decode_mode,
  output logic [NDEV*4-1:0]   intensity,
  output logic [NDEV*3-1:0]   scan_limit,
  output logic [NDEV-1:0]     shutdown,
  output logic [NDEV-1:0]     disp_test,
  output logic                update,
  output logic                frame_err
);

  localparam int unsigned SrW  = NDEV * 16;
  localparam int unsigned CntW = $clog2(SrW + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(SrW);
  localparam logic [CntW-1:0] CntSat  = CntW'(SrW + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   clk_prev_q, clk_prev_d;

  state_e                 state_q, state_d;
  logic [SrW-1:0]         sr_q, sr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [NDEV*64-1:0]     image_q, image_d;
  logic [NDEV*8-1:0]      decode_q, decode_d;
  logic [NDEV*4-1:0]      intensity_q, intensity_d;
  logic [NDEV*3-1:0]      scan_q, scan_d;
  logic [NDEV-1:0]        shutdown_q, shutdown_d;
  logic [NDEV-1:0]        test_q, test_d;
  logic                   update_q, update_d;
  logic                   err_q, err_d;

  logic                   din_s, cs_s, clk_s;
  logic                   cs_fall, cs_rise, clk_rise;
  logic [15:0]            word;

  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign clk_rise = ~clk_prev_q & clk_s;

  always_comb begin
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], leds_din};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], leds_cs};
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], leds_clk};
    cs_prev_d  = cs_s;
    clk_prev_d = clk_s;
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    image_d     = image_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    shutdown_d  = shutdown_q;
    test_d      = test_q;
    update_d    = 1'b0;
    err_d       = 1'b0;
    word        = '0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // A clk edge coinciding with the latch is dropped, so cs_rise takes priority.
        if (cs_rise) begin
          state_d = StIdle;
          if (cnt_q == CntFull) begin
            update_d = 1'b1;
            for (int d = 0; d < int'(NDEV); d++) begin
              word = sr_q[d*16 +: 16];
              case (word[11:8])
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                  image_d[d*64 + (int'(word[11:8]) - 1)*8 +: 8] = word[7:0];
                4'h9: decode_d[d*8 +: 8]    = word[7:0];
                4'hA: intensity_d[d*4 +: 4] = word[3:0];
                4'hB: scan_d[d*3 +: 3]      = word[2:0];
                4'hC: shutdown_d[d]         = ~word[0];
                4'hF: test_d[d]             = word[0];
                default: ;
              endcase
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (clk_rise) begin
          sr_d = {sr_q[SrW-2:0], din_s};
          if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_sync_q  <= '0;
      cs_sync_q   <= '1;
      clk_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      clk_prev_q  <= 1'b0;
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      image_q     <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      shutdown_q  <= '1;
      test_q      <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      din_sync_q  <= din_sync_d;
      cs_sync_q   <= cs_sync_d;
      clk_sync_q  <= clk_sync_d;
      cs_prev_q   <= cs_prev_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      image_q     <= image_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      shutdown_q  <= shutdown_d;
      test_q      <= test_d;
      update_q    <= update_d;
      err_q       <= err_d;
    end
  end

  assign image       = image_q;
  assign decode_mode = decode_q;
  assign intensity   = intensity_q;
  assign scan_limit  = scan_q;
  assign shutdown    = shutdown_q;
  assign disp_test   = test_q;
  assign update      = update_q;
  assign frame_err   = err_q;

endmodule
